// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: clips one (x,y,w,h,colour) command to the framebuffer
// and streams it into the VRAM write port, one pixel per clock, row-major.
module vram_rect_fill #(
  parameter int FB_WIDTH  = 256,
  parameter int FB_HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [11:0] cmd_color,
  output logic [15:0] vram_write_addr,
  output logic [15:0] vram_write_data,
  output logic        vram_write_en,
  output logic        busy,
  output logic        done
);

  localparam int          SH    = $clog2(FB_WIDTH);
  localparam logic [10:0] FBW11 = 11'(FB_WIDTH);
  localparam logic [10:0] FBH11 = 11'(FB_HEIGHT);
  localparam logic [15:0] FBW16 = 16'(FB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_FILL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_w;
  logic [9:0]  r_h;
  logic [11:0] r_color;

  logic [10:0] r_col;
  logic [10:0] r_row;
  logic [10:0] r_wcm1;
  logic [15:0] r_base;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_en;
  logic        r_busy;
  logic        r_done;

  logic [10:0] w_col_nxt;
  logic [10:0] w_row_nxt;
  logic [10:0] w_wcm1_nxt;
  logic [15:0] w_base_nxt;
  logic [15:0] w_addr_nxt;
  logic [15:0] w_data_nxt;
  logic        w_en_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  logic        w_accept;
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic [10:0] w_w11;
  logic [10:0] w_h11;
  logic [10:0] w_xroom;
  logic [10:0] w_yroom;
  logic [10:0] w_wc;
  logic [10:0] w_hc;
  logic        w_empty;
  logic [15:0] w_row_base;

  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;

  // 11-bit clip arithmetic so x/y beyond the screen never wrap
  assign w_x11   = {1'b0, r_x};
  assign w_y11   = {1'b0, r_y};
  assign w_w11   = {1'b0, r_w};
  assign w_h11   = {1'b0, r_h};
  assign w_xroom = FBW11 - w_x11;
  assign w_yroom = FBH11 - w_y11;
  assign w_wc    = (w_w11 < w_xroom) ? w_w11 : w_xroom;
  assign w_hc    = (w_h11 < w_yroom) ? w_h11 : w_yroom;
  assign w_empty = (r_w == 10'd0) || (r_h == 10'd0) ||
                   (w_x11 >= FBW11) || (w_y11 >= FBH11);

  assign w_row_base = ({6'd0, r_y} << SH) + {6'd0, r_x};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_wcm1_nxt  = r_wcm1;
    w_base_nxt  = r_base;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_en_nxt = 1'b0;
        if (w_accept) begin
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_empty) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_en_nxt    = 1'b1;
          w_addr_nxt  = w_row_base;
          w_base_nxt  = w_row_base;
          w_data_nxt  = {4'h0, r_color};
          w_col_nxt   = w_wc - 11'd1;
          w_wcm1_nxt  = w_wc - 11'd1;
          w_row_nxt   = w_hc - 11'd1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (r_col != 11'd0) begin
          w_addr_nxt = r_addr + 16'd1;
          w_col_nxt  = r_col - 11'd1;
        end else if (r_row != 11'd0) begin
          // row wrap stays back-to-back: next row start comes from row_base
          w_base_nxt = r_base + FBW16;
          w_addr_nxt = r_base + FBW16;
          w_col_nxt  = r_wcm1;
          w_row_nxt  = r_row - 11'd1;
        end else begin
          w_en_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
    end else if (w_accept) begin
      r_x     <= cmd_x;
      r_y     <= cmd_y;
      r_w     <= cmd_w;
      r_h     <= cmd_h;
      r_color <= cmd_color;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_wcm1 <= '0;
      r_base <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_en   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_wcm1 <= w_wcm1_nxt;
      r_base <= w_base_nxt;
      r_addr <= w_addr_nxt;
      r_data <= w_data_nxt;
      r_en   <= w_en_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign vram_write_addr = r_addr;
  assign vram_write_data = r_data;
  assign vram_write_en   = r_en;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
